// File: rtl/irq_capture8_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
// Shared definitions for the eight-line interrupt capture stage: line count,
// index width, the request vector type, the handshake FSM state encoding and
// a helper that expands an index into a one-hot line vector.
// ---------------------------------------------------------------------------
package irq_pkg;

    localparam int IRQ_N    = 8;
    localparam int IRQ_IDXW = 3;

    typedef logic [IRQ_N-1:0] irq_vec_t;

    typedef enum logic [0:0] {
        IRQ_IDLE,
        IRQ_PRESENT
    } irq_state_t;

    // One-hot line vector for a given request index.
    function automatic irq_vec_t irq_onehot(input logic [IRQ_IDXW-1:0] idx);
        irq_vec_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/irq_capture8_if.sv
// ---------------------------------------------------------------------------
// irq_capture8_if
// Bus between the capture stage, the external priority encoder and the
// request consumer.
//   pend_out  : masked pending vector, feeds encoder input A
//   enc_idx   : encoder output Y, returned combinationally
//   irq_valid : a request index is presented
//   irq_idx   : presented index, stable while irq_valid
//   irq_ack   : consumer accepts the presented request
// master = capture stage, slave = encoder/consumer side.
// ---------------------------------------------------------------------------
interface irq_capture8_if;
    import irq_pkg::*;

    irq_vec_t              pend_out;
    logic [IRQ_IDXW-1:0]   enc_idx;
    logic                  irq_valid;
    logic [IRQ_IDXW-1:0]   irq_idx;
    logic                  irq_ack;

    modport master (
        output pend_out,
        output irq_valid,
        output irq_idx,
        input  enc_idx,
        input  irq_ack
    );

    modport slave (
        input  pend_out,
        input  irq_valid,
        input  irq_idx,
        output enc_idx,
        output irq_ack
    );

endinterface

// File: rtl/irq_capture8_sync_bit_chain.sv
// ---------------------------------------------------------------------------
// sync_bit_chain
// Single-bit synchroniser: SYNC_STAGES flops in series (2 or 3), all cleared
// by a synchronous active-low reset.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   i_d   : asynchronous input bit
//   o_q   : synchronised output bit
// ---------------------------------------------------------------------------
module sync_bit_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/irq_capture8.sv
// ---------------------------------------------------------------------------
// irq_capture8
// Eight-line interrupt capture and service stage. Raw lines are synchronised,
// captured as edge or level requests into a pending register, masked onto
// pend_out for the external priority encoder, and the returned index is
// presented through a valid/ack handshake. Acking retires edge requests.
//   clk       : system clock, all state on rising edge
//   rst_n     : synchronous active-low reset
//   irq_in    : raw request lines (asynchronous)
//   edge_mode : 1 = rising-edge triggered, 0 = level triggered
//   mask      : 1 = line enabled onto pend_out
//   overflow  : sticky per-line lost-edge flags
//   ovf_clr   : clears all overflow flags
//   irq_bus   : pend_out / enc_idx / irq_valid / irq_idx / irq_ack
// ---------------------------------------------------------------------------
module irq_capture8
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int N           = IRQ_N,
    parameter int IDXW        = IRQ_IDXW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    irq_in,
    input  logic [N-1:0]    edge_mode,
    input  logic [N-1:0]    mask,
    input  logic            ovf_clr,
    output logic [N-1:0]    overflow,
    irq_capture8_if.master  irq_bus
);

    logic [N-1:0]    w_sync;
    logic [N-1:0]    w_rise;
    logic [N-1:0]    w_ack_vec;
    logic [N-1:0]    w_ovf_set;
    logic [N-1:0]    w_pend_next;
    logic [N-1:0]    w_pend_out;
    logic [N-1:0]    r_prev;
    logic [N-1:0]    r_pending;
    logic [N-1:0]    r_overflow;
    irq_state_t      r_state;
    logic [IDXW-1:0] r_irq_idx;
    logic            r_irq_valid;

    for (genvar g = 0; g < N; g++) begin : g_sync
        sync_bit_chain #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .i_d   (irq_in[g]),
            .o_q   (w_sync[g])
        );
    end

    // The line being retired this cycle, if any. Only an ack while a request
    // is actually presented counts; an ack in IDLE selects nothing.
    always_comb begin
        w_rise    = w_sync & ~r_prev;
        w_ack_vec = '0;
        if (r_state == IRQ_PRESENT && irq_bus.irq_ack) begin
            w_ack_vec = irq_onehot(r_irq_idx);
        end
        // Edge lines: a rise sets and beats a coincident ack clear.
        // Level lines: simply follow the synchronised input.
        w_pend_next = (edge_mode & ((r_pending & ~w_ack_vec) | w_rise))
                    | (~edge_mode & w_sync);
        // A rise lost onto an already-pending edge line, unless that line is
        // being retired this very cycle.
        w_ovf_set   = w_rise & edge_mode & r_pending & ~w_ack_vec;
        w_pend_out  = r_pending & mask;
    end

    // Capture path: previous-sample, pending and sticky overflow registers.
    // A fresh overflow set wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev     <= '0;
            r_pending  <= '0;
            r_overflow <= '0;
        end else begin
            r_prev    <= w_sync;
            r_pending <= w_pend_next;
            if (ovf_clr) begin
                r_overflow <= w_ovf_set;
            end else begin
                r_overflow <= r_overflow | w_ovf_set;
            end
        end
    end

    // Handshake FSM. The encoder index is latched on leaving IDLE and held
    // through PRESENT regardless of later mask/pending changes. Returning to
    // IDLE for one cycle after an ack lets pend_out show the retirement
    // before the encoder result is sampled again.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IRQ_IDLE;
            r_irq_idx   <= '0;
            r_irq_valid <= 1'b0;
        end else begin
            case (r_state)
                IRQ_IDLE: begin
                    if (w_pend_out != '0) begin
                        r_irq_idx   <= irq_bus.enc_idx;
                        r_irq_valid <= 1'b1;
                        r_state     <= IRQ_PRESENT;
                    end
                end
                IRQ_PRESENT: begin
                    if (irq_bus.irq_ack) begin
                        r_irq_valid <= 1'b0;
                        r_state     <= IRQ_IDLE;
                    end
                end
                default: begin
                    r_irq_valid <= 1'b0;
                    r_state     <= IRQ_IDLE;
                end
            endcase
        end
    end

    assign overflow          = r_overflow;
    assign irq_bus.pend_out  = w_pend_out;
    assign irq_bus.irq_valid = r_irq_valid;
    assign irq_bus.irq_idx   = r_irq_idx;

endmodule

// File: tb/tb_irq_capture8.sv
// ---------------------------------------------------------------------------
// tb_irq_capture8
// Directed bench for irq_capture8. A behavioural highest-bit priority encoder
// closes the loop from pend_out back to enc_idx. Each step advances to just
// after a rising edge and compares outputs against hand-derived values.
// ---------------------------------------------------------------------------
module tb_irq_capture8;
    import irq_pkg::*;

    logic       clk;
    logic       rst_n;
    irq_vec_t   irqIn;
    irq_vec_t   edgeMode;
    irq_vec_t   mask;
    logic       ovfClr;
    irq_vec_t   overflow;
    logic [2:0] encIdx;

    int vecCount  = 0;
    int missCount = 0;

    irq_capture8_if bus ();

    irq_capture8 #(
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irqIn),
        .edge_mode (edgeMode),
        .mask      (mask),
        .ovf_clr   (ovfClr),
        .overflow  (overflow),
        .irq_bus   (bus.master)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the downstream encoder: index of the highest set bit.
    always_comb begin
        encIdx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (bus.pend_out[i]) encIdx = 3'(i);
        end
    end
    assign bus.enc_idx = encIdx;

    // Advance n rising edges, leaving time 1 unit past the last one.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive lines high for exactly one sampling edge.
    task automatic pulse(input irq_vec_t lines);
        irqIn = lines;
        applyStimulus(1);
        irqIn = '0;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        vecCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Sequence of directed steps covering reset, edge capture, priority order,
    // masking, overflow corner cases, level lines and reset mid-handshake.
    initial begin
        rst_n       = 1'b0;
        irqIn       = 8'hFF;
        edgeMode    = 8'h00;
        mask        = 8'hFF;
        ovfClr      = 1'b0;
        bus.irq_ack = 1'b0;

        applyStimulus(3);
        checkOutput("rst_valid",    {7'd0, bus.irq_valid}, 8'h00);
        checkOutput("rst_pend_out", bus.pend_out,          8'h00);
        checkOutput("rst_overflow", overflow,              8'h00);

        rst_n = 1'b1;
        applyStimulus(2);
        checkOutput("lvl_pend_e2",  bus.pend_out,          8'h00);
        applyStimulus(1);
        checkOutput("lvl_pend_e3",  bus.pend_out,          8'hFF);
        checkOutput("lvl_valid_e3", {7'd0, bus.irq_valid}, 8'h00);
        applyStimulus(1);
        checkOutput("lvl_valid_e4", {7'd0, bus.irq_valid}, 8'h01);
        checkOutput("lvl_idx_e4",   {5'd0, bus.irq_idx},   8'd7);

        rst_n    = 1'b0;
        irqIn    = 8'h00;
        edgeMode = 8'hFF;
        applyStimulus(2);
        rst_n = 1'b1;
        applyStimulus(1);

        pulse(8'h04);
        applyStimulus(1);
        checkOutput("edge_valid_k1", {7'd0, bus.irq_valid}, 8'h00);
        applyStimulus(1);
        checkOutput("edge_pend_k2",  bus.pend_out,          8'h04);
        applyStimulus(1);
        checkOutput("edge_valid_k3", {7'd0, bus.irq_valid}, 8'h01);
        checkOutput("edge_idx_k3",   {5'd0, bus.irq_idx},   8'd2);
        bus.irq_ack = 1'b1;
        applyStimulus(1);
        bus.irq_ack = 1'b0;
        checkOutput("edge_pend_ack",  bus.pend_out,          8'h00);
        checkOutput("edge_valid_ack", {7'd0, bus.irq_valid}, 8'h00);

        pulse(8'h52);
        applyStimulus(2);
        checkOutput("prio_pend",   bus.pend_out,        8'h52);
        applyStimulus(1);
        checkOutput("prio_idx6",   {5'd0, bus.irq_idx}, 8'd6);
        bus.irq_ack = 1'b1;
        applyStimulus(1);
        bus.irq_ack = 1'b0;
        checkOutput("prio_gap1",   {7'd0, bus.irq_valid}, 8'h00);
        checkOutput("prio_pend1",  bus.pend_out,          8'h12);
        applyStimulus(1);
        checkOutput("prio_valid4", {7'd0, bus.irq_valid}, 8'h01);
        checkOutput("prio_idx4",   {5'd0, bus.irq_idx},   8'd4);
        bus.irq_ack = 1'b1;
        applyStimulus(1);
        bus.irq_ack = 1'b0;
        checkOutput("prio_pend2",  bus.pend_out,        8'h02);
        applyStimulus(1);
        checkOutput("prio_idx1",   {5'd0, bus.irq_idx}, 8'd1);
        bus.irq_ack = 1'b1;
        applyStimulus(1);
        bus.irq_ack = 1'b0;
        checkOutput("prio_pend3",  bus.pend_out,        8'h00);

        mask = 8'hEF;
        pulse(8'h10);
        applyStimulus(3);
        checkOutput("mask_valid",   {7'd0, bus.irq_valid}, 8'h00);
        checkOutput("mask_pendout", bus.pend_out,          8'h00);
        checkOutput("mask_pending", dut.r_pending,         8'h10);
        mask = 8'hFF;
        applyStimulus(1);
        checkOutput("unmask_valid", {7'd0, bus.irq_valid}, 8'h01);
        checkOutput("unmask_idx",   {5'd0, bus.irq_idx},   8'd4);
        bus.irq_ack = 1'b1;
        applyStimulus(1);
        bus.irq_ack = 1'b0;
        applyStimulus(1);

        pulse(8'h08);
        applyStimulus(3);
        checkOutput("ovf_idx3",   {5'd0, bus.irq_idx}, 8'd3);
        pulse(8'h08);
        applyStimulus(2);
        checkOutput("ovf_set",    overflow,            8'h08);
        checkOutput("ovf_held",   {7'd0, bus.irq_valid}, 8'h01);
        ovfClr = 1'b1;
        applyStimulus(1);
        ovfClr = 1'b0;
        checkOutput("ovf_clr",    overflow,            8'h00);
        pulse(8'h08);
        applyStimulus(1);
        bus.irq_ack = 1'b1;
        applyStimulus(1);
        bus.irq_ack = 1'b0;
        checkOutput("coin_pend",  bus.pend_out,          8'h08);
        checkOutput("coin_ovf",   overflow,              8'h00);
        checkOutput("coin_valid", {7'd0, bus.irq_valid}, 8'h00);
        applyStimulus(1);
        checkOutput("coin_repres", {5'd0, bus.irq_idx},  8'd3);
        bus.irq_ack = 1'b1;
        applyStimulus(1);
        bus.irq_ack = 1'b0;
        applyStimulus(1);

        edgeMode = 8'hDF;
        irqIn    = 8'h20;
        applyStimulus(4);
        checkOutput("lv5_valid",  {7'd0, bus.irq_valid}, 8'h01);
        checkOutput("lv5_idx",    {5'd0, bus.irq_idx},   8'd5);
        bus.irq_ack = 1'b1;
        applyStimulus(1);
        bus.irq_ack = 1'b0;
        checkOutput("lv5_gap",    {7'd0, bus.irq_valid}, 8'h00);
        checkOutput("lv5_pend",   bus.pend_out,          8'h20);
        applyStimulus(1);
        checkOutput("lv5_repres", {7'd0, bus.irq_valid}, 8'h01);
        rst_n = 1'b0;
        applyStimulus(1);
        checkOutput("mrst_valid", {7'd0, bus.irq_valid}, 8'h00);
        checkOutput("mrst_pend",  dut.r_pending,         8'h00);
        checkOutput("mrst_idx",   {5'd0, bus.irq_idx},   8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/irq_capture8.md
Name: irq_capture8

Overview:
Eight-line interrupt capture and service stage that sits directly upstream of the team's 8-bit priority encoder. It synchronises the raw request lines, latches edge or level requests into a pending register, and applies the enable mask. The masked pending vector drives the encoder. The block takes the encoder's 3-bit index back and presents it to the consumer through a valid/ack handshake, then retires the serviced request.

Parameters:
SYNC_STAGES, 2, flops in each input synchroniser chain (allowed values 2 or 3)
N, 8, number of request lines (fixed at 8 to match the 8-input encoder; not meant to be overridden)
IDXW, 3, index width, equal to log2(N)

Ports:
clk  in  1  single system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
irq_in  in  8  raw request lines, asynchronous to clk
edge_mode  in  8  per line: 1 = rising-edge triggered, 0 = level triggered
mask  in  8  per line: 1 = enabled
pend_out  out  8  pending & mask, registered sources only; drives encoder input A
enc_idx  in  3  encoder output Y, combinational return from downstream encoder
irq_valid  out  1  a request index is presented
irq_idx  out  3  index of the presented request; stable while irq_valid
irq_ack  in  1  consumer accepts the presented request
overflow  out  8  sticky per-line flag: edge request lost because the line was already pending
ovf_clr  in  1  clears all overflow bits

Behaviour:
- Reset (rst_n=0 at a clk edge): synchroniser flops, prev-sample flops, pending, overflow and irq_idx all go to 0; FSM goes to IDLE; irq_valid=0; pend_out=0. Reset mid-handshake drops the presented request without retiring anything.
- Sync: each irq_in bit passes through SYNC_STAGES flops (s). prev <= s every cycle. rise = s & ~prev.
- Pending, edge line: set on rise; cleared when acked; rise in the same cycle as the ack of that line leaves the bit set (set wins).
- Pending, level line: pending[i] <= s[i] every cycle; ack has no effect on it. A line still high re-asserts.
- Overflow: rise on an edge line whose pending bit is 1 and is not being acked that cycle sets overflow[i]. ovf_clr clears all bits; a new set in the same cycle wins. Level lines never set overflow.
- Mask: masked lines still capture into pending; they are only hidden from pend_out. Unmasking a pending line makes it eligible on the next evaluation.
- FSM, two states:
  - IDLE: irq_valid=0. If pend_out != 0, then irq_idx <= enc_idx and the FSM goes to PRESENT.
  - PRESENT: irq_valid=1, irq_idx held. On irq_ack=1, the edge-mode pending[irq_idx] is cleared and the FSM goes to IDLE. Mask or pend_out changes while in PRESENT do not retract or alter the presented request.
  - irq_ack while in IDLE is ignored.
- Minimum gap of 1 IDLE cycle between consecutive presentations, so pend_out reflects the clear before re-encoding.
- Latency (SYNC_STAGES=2): irq_in first sampled high at edge k -> s=1 at k+1 -> pending=1 at k+2 -> irq_valid=1 at k+3.
- The block assumes enc_idx is the highest set bit of pend_out, matching the encoder's priority. An all-zero pend_out is never latched.

Decomposition:
- Shared package irq_pkg: IRQ_N=8, IRQ_IDXW=3, the FSM enum irq_state_t {IRQ_IDLE, IRQ_PRESENT}, and a typedef irq_vec_t = logic [7:0].
- One natural sub-module: sync_bit_chain (per-bit SYNC_STAGES-flop synchroniser with synchronous active-low reset), instantiated 8 times.
- The encoder stays external. The bench instantiates it between pend_out and enc_idx.

Test Plan:
- Reset: hold rst_n=0 with irq_in=8'hFF -> irq_valid=0, pend_out=0, overflow=0. Release reset with lines high and level mode, mask=8'hFF -> pend_out=8'hFF at edge 3, irq_idx=7.
- Single edge: edge_mode=8'hFF, mask=8'hFF, pulse irq_in[2] for 1 cycle at edge k -> irq_valid at k+3 with irq_idx=2. Ack -> pend_out=0 next cycle, irq_valid=0.
- Priority and retire order: rises on lines 1, 4 and 6 in the same cycle -> presentations 6, 4, 1, each after ack and a 1-cycle IDLE gap.
- Mask: mask=8'hEF, pulse line 4 -> no irq_valid and pending[4]=1. Set mask=8'hFF -> irq_valid with irq_idx=4.
- Overflow and simultaneous events: line 3 pending and unacked, second rise -> overflow[3]=1. Rise coinciding with ack of 3 -> pending[3] stays 1 and overflow unchanged. ovf_clr -> overflow=0.
- Level line and mid-handshake reset: edge_mode[5]=0, irq_in[5] held high, ack -> represented after the gap. Assert rst_n=0 while in PRESENT -> irq_valid=0 and pending=0 next edge.
